// File: rtl/cpu_pila_pkg.sv
// Shared definitions for the cpu_pila stack-machine core: opcodes, instruction
// field positions and the decoded-instruction payload.
package cpu_pila_pkg;

    localparam int unsigned IW      = 16;
    localparam int unsigned NREG    = 16;
    localparam int unsigned RIDX_W  = 4;

    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RA_MSB  = 7;
    localparam int unsigned RA_LSB  = 4;
    localparam int unsigned RB_MSB  = 3;
    localparam int unsigned RB_LSB  = 0;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_NOT  = 4'h5,
        OP_LI   = 4'h6,
        OP_IN   = 4'h7,
        OP_OUT  = 4'h8,
        OP_J    = 4'h9,
        OP_JZ   = 4'hA,
        OP_JNZ  = 4'hB,
        OP_CALL = 4'hC,
        OP_RET  = 4'hD,
        OP_HALT = 4'hE,
        OP_RSV  = 4'hF
    } opcode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    typedef struct packed {
        opcode_e           op;
        logic [RIDX_W-1:0] rd;
        logic [RIDX_W-1:0] ra;
        logic [RIDX_W-1:0] rb;
        logic [7:0]        imm8;
    } instr_t;

    function automatic instr_t decode(input logic [IW-1:0] w);
        instr_t d;
        d.op   = opcode_e'(w[OP_MSB:OP_LSB]);
        d.rd   = w[RD_MSB:RD_LSB];
        d.ra   = w[RA_MSB:RA_LSB];
        d.rb   = w[RB_MSB:RB_LSB];
        d.imm8 = w[IMM_MSB:IMM_LSB];
        return d;
    endfunction

endpackage

// File: rtl/pila_retorno.sv
// Return-address stack for CALL/RET; the pointer counts 0..SDEPTH so full and
// empty are exact and an overflowing push or underflowing pop is ignored.
module pila_retorno #(
    parameter int unsigned AW     = 10,
    parameter int unsigned SDEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic          full,
    output logic          empty
);

    localparam int unsigned PW = $clog2(SDEPTH);
    localparam logic [PW:0] LP_FULL = (PW+1)'(SDEPTH);

    logic [AW-1:0] r_mem [SDEPTH];
    logic [PW:0]   r_sp;
    logic [PW-1:0] w_top_idx;

    assign w_top_idx = PW'(r_sp - 1'b1);
    assign top       = r_mem[w_top_idx];
    assign full      = (r_sp == LP_FULL);
    assign empty     = (r_sp == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp <= '0;
        end else if (push && !full) begin
            r_sp <= r_sp + 1'b1;
        end else if (pop && !empty) begin
            r_sp <= r_sp - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read after being pushed.
    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            r_mem[r_sp[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/cpu_pila.sv
// cpu_pila: single-cycle 16-register core with a return stack and
// handshaked IN/OUT ports that stall the pc until the transfer completes.
module cpu_pila
    import cpu_pila_pkg::*;
#(
    parameter int unsigned DW     = 16,
    parameter int unsigned AW     = 10,
    parameter int unsigned SDEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] pc,
    input  logic [IW-1:0] instr,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          z,
    output logic          ovf,
    output logic          halted,
    output logic          stack_err
);

    state_e        r_state, w_state_nxt;
    logic [AW-1:0] r_pc, w_pc_nxt, w_pc_inc, w_addr, w_top;
    logic [DW-1:0] r_regs [NREG];
    logic          r_z, r_ovf, r_err;
    logic          w_z_nxt, w_ovf_nxt, w_err_nxt;
    logic          w_we, w_push, w_pop, w_full, w_empty;
    logic          w_in_ready, w_out_valid;
    logic [DW-1:0] w_wdata, w_a, w_b, w_add, w_sub;
    instr_t        w_ins;

    assign w_ins    = decode(instr);
    assign w_addr   = instr[AW-1:0];
    assign w_pc_inc = r_pc + 1'b1;
    assign w_a      = (w_ins.ra == '0) ? '0 : r_regs[w_ins.ra];
    assign w_b      = (w_ins.rb == '0) ? '0 : r_regs[w_ins.rb];
    assign w_add    = w_a + w_b;
    assign w_sub    = w_a - w_b;

    pila_retorno #(
        .AW     (AW),
        .SDEPTH (SDEPTH)
    ) u_pila (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top       (w_top),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Next-state, next-pc, writeback and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_we        = 1'b0;
        w_wdata     = '0;
        w_z_nxt     = r_z;
        w_ovf_nxt   = r_ovf;
        w_err_nxt   = r_err;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        if (r_state == ST_RUN) begin
            w_pc_nxt = w_pc_inc;
            case (w_ins.op)
                OP_ADD: begin
                    w_we      = 1'b1;
                    w_wdata   = w_add;
                    w_z_nxt   = (w_add == '0);
                    w_ovf_nxt = (w_a[DW-1] == w_b[DW-1]) && (w_add[DW-1] != w_a[DW-1]);
                end
                OP_SUB: begin
                    w_we      = 1'b1;
                    w_wdata   = w_sub;
                    w_z_nxt   = (w_sub == '0);
                    w_ovf_nxt = (w_a[DW-1] != w_b[DW-1]) && (w_sub[DW-1] != w_a[DW-1]);
                end
                OP_AND: begin
                    w_we    = 1'b1;
                    w_wdata = w_a & w_b;
                    w_z_nxt = ((w_a & w_b) == '0);
                end
                OP_OR: begin
                    w_we    = 1'b1;
                    w_wdata = w_a | w_b;
                    w_z_nxt = ((w_a | w_b) == '0);
                end
                OP_NOT: begin
                    w_we    = 1'b1;
                    w_wdata = ~w_a;
                    w_z_nxt = (~w_a == '0);
                end
                OP_LI: begin
                    w_we    = 1'b1;
                    w_wdata = DW'(w_ins.imm8);
                end
                OP_IN: begin
                    if (in_valid) begin
                        w_in_ready = 1'b1;
                        w_we       = 1'b1;
                        w_wdata    = in_data;
                    end else begin
                        w_pc_nxt = r_pc;
                    end
                end
                OP_OUT: begin
                    w_out_valid = 1'b1;
                    if (!out_ready) w_pc_nxt = r_pc;
                end
                OP_J:   w_pc_nxt = w_addr;
                OP_JZ:  if (r_z)  w_pc_nxt = w_addr;
                OP_JNZ: if (!r_z) w_pc_nxt = w_addr;
                OP_CALL: begin
                    if (w_full) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_HALT;
                        w_pc_nxt    = r_pc;
                    end else begin
                        w_push   = 1'b1;
                        w_pc_nxt = w_addr;
                    end
                end
                OP_RET: begin
                    if (w_empty) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_HALT;
                        w_pc_nxt    = r_pc;
                    end else begin
                        w_pop    = 1'b1;
                        w_pc_nxt = w_top;
                    end
                end
                OP_HALT: begin
                    w_state_nxt = ST_HALT;
                    w_pc_nxt    = r_pc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= '0;
            r_z     <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_z     <= w_z_nxt;
            r_ovf   <= w_ovf_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Register file; r0 is never written so it stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (w_we && (w_ins.rd != '0)) begin
            r_regs[w_ins.rd] <= w_wdata;
        end
    end

    assign pc        = r_pc;
    assign z         = r_z;
    assign ovf       = r_ovf;
    assign halted    = (r_state == ST_HALT);
    assign stack_err = r_err;
    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_a;

endmodule

// File: tb/tb_cpu_pila.sv
// Self-checking bench for cpu_pila: directed scenarios plus random programs,
// all compared every cycle against an instruction-level model.
module tb_cpu_pila;

    localparam int unsigned DW = 16, AW = 10, SDEPTH = 8, MEMN = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc;
    logic [15:0]   instr;
    logic [DW-1:0] in_data, out_data;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic          z, ovf, halted, stack_err;

    logic [15:0] mem [MEMN];
    assign instr = mem[pc];

    always #5 clk = ~clk;

    cpu_pila #(.DW(DW), .AW(AW), .SDEPTH(SDEPTH)) dut (
        .clk(clk), .reset(reset), .pc(pc), .instr(instr),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .ovf(ovf), .halted(halted), .stack_err(stack_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    int m_regs [16];
    int m_pc;
    bit m_z, m_ovf, m_halt, m_err;
    int m_stk [$];

    function automatic int sx(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 0; m_z = 0; m_ovf = 0; m_halt = 0; m_err = 0;
            foreach (m_regs[i]) m_regs[i] = 0;
            m_stk.delete();
        end else if (!m_halt) begin
            int ins, op, rd, a, b, r, s, npc, addr;
            bit wr;
            ins  = int'(mem[m_pc]);
            op   = ins / 4096;
            rd   = (ins / 256) % 16;
            a    = m_regs[(ins / 16) % 16];
            b    = m_regs[ins % 16];
            addr = ins % 1024;
            npc  = (m_pc + 1) % 1024;
            wr   = 0;
            r    = 0;
            case (op)
                1: begin r = (a + b) % 65536; s = sx(a) + sx(b);
                         m_ovf = (s > 32767) || (s < -32768); m_z = (r == 0); wr = 1; end
                2: begin r = (a - b + 65536) % 65536; s = sx(a) - sx(b);
                         m_ovf = (s > 32767) || (s < -32768); m_z = (r == 0); wr = 1; end
                3: begin r = a & b; m_z = (r == 0); wr = 1; end
                4: begin r = a | b; m_z = (r == 0); wr = 1; end
                5: begin r = 65535 - a; m_z = (r == 0); wr = 1; end
                6: begin r = ins % 256; wr = 1; end
                7: if (in_valid) begin r = int'(in_data); wr = 1; end else npc = m_pc;
                8: if (!out_ready) npc = m_pc;
                9: npc = addr;
                10: if (m_z) npc = addr;
                11: if (!m_z) npc = addr;
                12: if (m_stk.size() == SDEPTH) begin m_err = 1; m_halt = 1; npc = m_pc; end
                    else begin m_stk.push_back(npc); npc = addr; end
                13: if (m_stk.size() == 0) begin m_err = 1; m_halt = 1; npc = m_pc; end
                    else npc = m_stk.pop_back();
                14: begin m_halt = 1; npc = m_pc; end
                default: ;
            endcase
            if (wr && rd != 0) m_regs[rd] = r;
            m_pc = npc;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            int ins, op;
            bit e_inr, e_outv;
            ins    = int'(mem[m_pc]);
            op     = ins / 4096;
            e_inr  = !m_halt && op == 7 && in_valid;
            e_outv = !m_halt && op == 8;
            chk("pc", 32'(pc), 32'(m_pc));
            chk("z", 32'(z), 32'(m_z));
            chk("ovf", 32'(ovf), 32'(m_ovf));
            chk("halted", 32'(halted), 32'(m_halt));
            chk("stack_err", 32'(stack_err), 32'(m_err));
            chk("in_ready", 32'(in_ready), 32'(e_inr));
            chk("out_valid", 32'(out_valid), 32'(e_outv));
            if (e_outv) chk("out_data", 32'(out_data), 32'(m_regs[(ins / 16) % 16]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < MEMN; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        step();
        reset = 1'b0;
    endtask

    int pulses;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        clear_mem();
        step();
        check_en = 1'b1;

        // Equal operands subtract to zero.
        clear_mem();
        mem[0] = 16'h6105; mem[1] = 16'h6205; mem[2] = 16'h2312;
        mem[3] = 16'h8030; mem[4] = 16'hE000;
        do_reset();
        chk("rst_pc", 32'(pc), 0);
        chk("rst_z", 32'(z), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_err", 32'(stack_err), 0);
        repeat (3) step();
        chk("sub_pc", 32'(pc), 3);
        chk("sub_z", 32'(z), 1);
        chk("sub_ovf", 32'(ovf), 0);
        chk("sub_r3", 32'(out_data), 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        chk("halt_flag", 32'(halted), 1);
        step();
        chk("halt_pc", 32'(pc), 4);

        // Doubling 0x7F until the sign bit flips.
        clear_mem();
        mem[0] = 16'h617F;
        for (int i = 1; i <= 9; i++) mem[i] = 16'h1111;
        mem[10] = 16'h8010; mem[11] = 16'hE000;
        do_reset();
        repeat (9) step();
        chk("dbl_pc", 32'(pc), 9);
        chk("dbl_ovf_before", 32'(ovf), 0);
        step();
        chk("dbl_ovf_after", 32'(ovf), 1);
        chk("dbl_r1", 32'(out_data), 32'hFE00);

        // IN stall then OUT stall.
        clear_mem();
        mem[0] = 16'h7400; mem[1] = 16'h8040; mem[2] = 16'hE000;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            chk("in_hold_pc", 32'(pc), 0);
            pulses += int'(in_ready);
            step();
        end
        in_valid = 1'b1; in_data = 16'h1234;
        #1;
        pulses += int'(in_ready);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            pulses += int'(in_ready);
            chk("out_hold_pc", 32'(pc), 1);
            chk("out_hold_valid", 32'(out_valid), 1);
            chk("out_hold_data", 32'(out_data), 32'h1234);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("in_pulses", 32'(pulses), 1);
        chk("out_done_pc", 32'(pc), 2);

        // Nine nested CALLs overflow an 8-deep stack.
        clear_mem();
        for (int i = 0; i < 9; i++) mem[i] = 16'(32'hC000 + i + 1);
        do_reset();
        repeat (8) step();
        chk("call8_halted", 32'(halted), 0);
        step();
        chk("call9_err", 32'(stack_err), 1);
        chk("call9_halted", 32'(halted), 1);
        chk("call9_pc", 32'(pc), 8);

        clear_mem();
        mem[0] = 16'hD000;
        do_reset();
        step();
        chk("ret0_err", 32'(stack_err), 1);
        chk("ret0_halted", 32'(halted), 1);

        // Reset during an OUT stall abandons the transfer.
        clear_mem();
        mem[0] = 16'h6105; mem[1] = 16'h2211; mem[2] = 16'h8020; mem[3] = 16'hE000;
        do_reset();
        repeat (3) step();
        chk("stall_pc", 32'(pc), 2);
        chk("stall_z", 32'(z), 1);
        reset = 1'b1; out_ready = 1'b1;
        step();
        reset = 1'b0; out_ready = 1'b0;
        chk("rst_stall_pc", 32'(pc), 0);
        chk("rst_stall_outv", 32'(out_valid), 0);
        chk("rst_stall_z", 32'(z), 0);
        chk("rst_stall_ovf", 32'(ovf), 0);

        // Random programs with random handshakes and occasional resets.
        for (int p = 0; p < 12; p++) begin
            clear_mem();
            for (int i = 0; i < 63; i++) begin
                int op;
                op = int'($urandom_range(0, 15));
                if (op == 14 && $urandom_range(0, 7) != 0) op = 0;
                if (op >= 9 && op <= 12) mem[i] = 16'(op * 4096 + int'($urandom_range(0, 62)));
                else mem[i] = 16'(op * 4096 + int'($urandom_range(0, 4095)));
            end
            mem[63] = 16'h9000;
            do_reset();
            for (int c = 0; c < 300; c++) begin
                in_valid  = ($urandom_range(0, 1) == 1);
                out_ready = ($urandom_range(0, 1) == 1);
                in_data   = 16'($urandom);
                reset     = ($urandom_range(0, 99) == 0);
                step();
            end
            reset = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_pila.md
CPU_PILA -- requirements
Module: cpu_pila

Interface
REQ-001 SHALL have parameter DW, default 16: data/register width, DW >= 8.
REQ-002 SHALL have parameter AW, default 10: program counter width, 4 <= AW <= 12.
REQ-003 SHALL have parameter SDEPTH, default 8: return-stack entries, power of two >= 2.
REQ-004 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port pc, output, AW: current instruction address to program memory.
REQ-007 SHALL have port instr, input, 16: instruction at pc, valid combinationally in the same cycle.
REQ-008 SHALL have ports in_data (input, DW), in_valid (input, 1) and in_ready (output, 1): input-port handshake.
REQ-009 SHALL have ports out_data (output, DW), out_valid (output, 1) and out_ready (input, 1): output-port handshake.
REQ-010 SHALL have ports z, ovf, halted and stack_err, each output, 1: zero flag, signed-overflow flag, halt status and sticky stack fault.

Function
REQ-011 SHALL execute single-cycle except IN/OUT stalls; fields: op=instr[15:12], rd=[11:8], ra=[7:4], rb=[3:0], imm8=[7:0], addr=instr[AW-1:0].
REQ-012 SHALL provide 16 DW-bit registers, 2 combinational reads and 1 synchronous write; r0 reads 0 and writes to it are discarded.
REQ-013 SHALL decode 0 NOP; 1 ADD rd=ra+rb; 2 SUB rd=ra-rb; 3 AND; 4 OR; 5 NOT rd=~ra; 6 LI rd=zero-extended imm8.
REQ-014 SHALL decode 7 IN rd; 8 OUT ra; 9 J addr; A JZ addr; B JNZ addr; C CALL addr; D RET; E HALT; F as NOP.
REQ-015 SHALL take arithmetic modulo 2^DW; only ops 1-5 update z (result==0); only ADD/SUB update ovf (signed overflow); other ops keep both flags.
REQ-016 SHALL set next pc to pc+1 modulo 2^AW unless a taken jump, CALL, RET or stall applies.
REQ-017 SHALL take JZ when z=1 and JNZ when z=0, using the flag value before the current edge.
REQ-018 SHALL on CALL push pc+1 and jump to addr; on RET pop into pc; stack pointer counts 0..SDEPTH.
REQ-019 SHALL on CALL with SDEPTH entries, or RET with 0 entries, leave stack unchanged, set stack_err=1 and halted=1.
REQ-020 SHALL on IN drive in_ready=1 combinationally when in_valid=1; on that edge write in_data to rd and advance pc; otherwise hold pc and in_ready=0.
REQ-021 SHALL on OUT drive out_valid=1 and out_data=ra contents; advance pc on the edge where out_ready=1; otherwise hold all state.
REQ-022 SHALL keep in_ready=0 and out_valid=0 outside IN/OUT and while halted; out_data is don't-care when out_valid=0.
REQ-023 SHALL on HALT set halted=1; while halted, hold pc, registers, flags and stack until reset.

Reset
REQ-024 SHALL on reset set pc=0, all registers 0, z=0, ovf=0, stack pointer 0, halted=0 and stack_err=0.
REQ-025 SHALL give reset priority over every operation, abandoning any pending IN/OUT stall without completing a transfer.

Structure
REQ-026 SHALL place opcode constants and field bit positions in shared package cpu_pila_pkg.
REQ-027 SHALL implement the return stack as sub-module pila_retorno (parameters AW, SDEPTH; push, pop, full, empty outputs).

Verification
REQ-028 SHALL test LI r1,5; LI r2,5; SUB r3,r1,r2 -> r3=0, z=1, ovf=0, pc=3.
REQ-029 SHALL test with DW=16: LI r1,0x7F; repeated ADD r1,r1,r1 until bit 15 sets -> ovf=1 on the first sign-changing ADD.
REQ-030 SHALL test IN r4 with in_valid low 3 cycles and then high with in_data=0x1234 -> pc held 3 cycles, single in_ready pulse, r4=0x1234.
REQ-031 SHALL test OUT r4 with out_ready low 2 cycles -> out_valid=1 and out_data=0x1234 throughout; pc advances once.
REQ-032 SHALL test SDEPTH=8 with nine nested CALLs -> stack_err=1 and halted=1 after the ninth; RET at depth 0 in a fresh run gives the same result.
REQ-033 SHALL test reset asserted during an OUT stall -> next cycle pc=0, out_valid=0 and all flags 0.
